hc32_quad_or: RTL and testbench

- Synthesizable model of a 74HC32 quad 2-input OR package, used as a glue-logic primitive in board-level replicas.
- Each gate drives a combinational output Y = A | B and a registered copy. A per-gate change strobe and a saturating transition counter support activity and coverage monitoring.
- Sits between the surrounding logic-chip models and the system bus; one instance models one package.

---
 rtl/hc32_pkg.sv | 7 +
 rtl/hc32_or_slice.sv | 45 ++++
 rtl/hc32_quad_or.sv | 31 +++
 tb/tb_hc32_quad_or.sv | 134 +++++++++++++
 4 files changed

// File: rtl/hc32_pkg.sv
// Shared defaults and types for the hc32 quad-OR package model.
package hc32_pkg;
  localparam int NUM_GATES_DEF = 4;
  localparam int CNT_W_DEF     = 8;

  typedef logic [CNT_W_DEF-1:0] cnt_t;
endpackage

// File: rtl/hc32_or_slice.sv
// One OR gate: combinational output, registered copy, change strobe and
// saturating transition counter.
module hc32_or_slice #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_q,
  output logic             y_chg,
  output logic [CNT_W-1:0] cnt
);
  logic y_q_prev;
  logic trans;

  assign y = a | b;

  // A transition is committed on the edge where the new y differs from y_q.
  assign trans = y ^ y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= 1'b0;
      y_q_prev <= 1'b0;
    end else begin
      y_q      <= y;
      y_q_prev <= y_q;
    end
  end

  // Both operands are flops, so the strobe is clean for a full cycle.
  assign y_chg = y_q ^ y_q_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (cnt_clr)
      cnt <= '0;
    else if (trans && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/hc32_quad_or.sv
// 74HC32 quad 2-input OR package: NUM_GATES independent gate slices.
module hc32_quad_or
  import hc32_pkg::*;
#(
  parameter int NUM_GATES = NUM_GATES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_GATES-1:0]       a,
  input  logic [NUM_GATES-1:0]       b,
  output logic [NUM_GATES-1:0]       y,
  output logic [NUM_GATES-1:0]       y_q,
  output logic [NUM_GATES-1:0]       y_chg,
  input  logic                       cnt_clr,
  output logic [NUM_GATES*CNT_W-1:0] tog_cnt
);
  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    hc32_or_slice #(.CNT_W(CNT_W)) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a[g]),
      .b       (b[g]),
      .cnt_clr (cnt_clr),
      .y       (y[g]),
      .y_q     (y_q[g]),
      .y_chg   (y_chg[g]),
      .cnt     (tog_cnt[g*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_hc32_quad_or.sv
// Directed bench for hc32_quad_or (4 gates, 4-bit counters).
module tb_hc32_quad_or;
  localparam int NG = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NG-1:0] a, b, y, y_q, y_chg;
  logic          cnt_clr;
  logic [NG*CW-1:0] tog_cnt;

  int n_vec = 0;
  int n_err = 0;

  hc32_quad_or #(.NUM_GATES(NG), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .y       (y),
    .y_q     (y_q),
    .y_chg   (y_chg),
    .cnt_clr (cnt_clr),
    .tog_cnt (tog_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] ta, tb_, ty, tchg;
  int pulses;

  initial begin
    rst_n = 1'b0; a = '0; b = '0; cnt_clr = 1'b0;
    #3;
    check("rst_y_q",   16'(y_q),   16'h0);
    check("rst_y_chg", 16'(y_chg), 16'h0);
    check("rst_cnt",   tog_cnt,    16'h0);

    // Truth table on gate 0, evaluated while still in reset
    ta = 5'b00110; tb_ = 5'b01100; ty = 5'b01110;
    for (int k = 0; k < 5; k++) begin
      a[0] = ta[k]; b[0] = tb_[k];
      #5;
      check($sformatf("tt_y0_%0d", k), 16'(y[0]), 16'(ty[k]));
    end
    check("tt_y_q_held", 16'(y_q), 16'h0);

    // Registered path from reset release
    a = '0; b = '0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    tchg = 5'b10010;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      a[0] = ta[k]; b[0] = tb_[k];
      tick();
      check($sformatf("seq_y_q0_%0d", k), 16'(y_q[0]), 16'(ty[k]));
      check($sformatf("seq_chg0_%0d", k), 16'(y_chg[0]), 16'(tchg[k]));
      if (y_chg[0] === 1'b1) pulses++;
    end
    check("seq_pulses", 16'(pulses), 16'd2);
    check("seq_cnt0",   tog_cnt,     16'h0002);
    tick();
    check("seq_chg_idle", 16'(y_chg), 16'h0);

    // Independence across gates
    a = 4'b0101; b = 4'b0011;
    #1;
    check("ind_y", 16'(y), 16'h0007);
    tick();
    check("ind_y_q",   16'(y_q),   16'h0007);
    check("ind_y_chg", 16'(y_chg), 16'h0007);
    check("ind_cnt",   tog_cnt,    16'h0113);

    // Saturation on gate 1 (count starts at 1)
    for (int k = 0; k < 20; k++) begin
      b[1] = ~b[1];
      tick();
    end
    check("sat_cnt1", 16'(tog_cnt[7:4]), 16'd15);
    b[1] = ~b[1];
    tick();
    check("sat_hold", 16'(tog_cnt[7:4]), 16'd15);

    // Clear coinciding with a transition on gate 1
    b[1] = ~b[1]; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt",   tog_cnt,         16'h0);
    check("clr_y_q1",  16'(y_q[1]),     16'h1);
    check("clr_chg1",  16'(y_chg[1]),   16'h1);

    // Build y_q=1111 with known nonzero counts
    a = '0; b = '0;
    tick();
    a = 4'hF;
    tick();
    check("pre_rst_y_q", 16'(y_q), 16'h000F);
    check("pre_rst_cnt", tog_cnt,  16'h1222);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("arst_y_q",   16'(y_q),   16'h0);
    check("arst_y_chg", 16'(y_chg), 16'h0);
    check("arst_cnt",   tog_cnt,    16'h0);
    check("arst_y",     16'(y),     16'h000F);
    a = '0;
    #1;
    check("arst_y_track", 16'(y), 16'h0);
    a = 4'b0001;
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_y_q",   16'(y_q),   16'h0001);
    check("post_y_chg", 16'(y_chg), 16'h0001);
    check("post_cnt",   tog_cnt,    16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
